// File: rtl/instr_mem_loader.sv
// Assembles a little-endian host byte stream into 32-bit words and writes them to instruction memory.
// Optional checksum byte after the payload when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_DONE
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [23:0]           asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      len_q      <= '0;
      asm_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    byte_ready = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (length == '0) begin
`ifdef LOADER_CHECKSUM_EN
            // Empty payload still requires its checksum byte (expected 0x00).
            state_d = S_CSUM;
            csum_d  = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
            error_d = 1'b0;
`endif
          end else if (length > ADDR_WIDTH'(MEM_DEPTH)) begin
            state_d = S_DONE;
            done_d  = 1'b0;
            error_d = 1'b1;
          end else begin
            state_d    = S_RECV;
            done_d     = 1'b0;
            error_d    = 1'b0;
            byte_cnt_d = '0;
            word_idx_d = '0;
            len_d      = length;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
          end
        end
      end
      S_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_data;
`endif
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = byte_data;
            2'd1: asm_d[15:8]  = byte_data;
            2'd2: asm_d[23:16] = byte_data;
            default: begin
              wdata_d = {byte_data, asm_q};
              addr_d  = ADDR_WIDTH'(BASE_ADDR) + {word_idx_q[ADDR_WIDTH-3:0], 2'b00};
              state_d = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        mem_we     = 1'b1;
        busy       = 1'b1;
        word_idx_d = word_idx_q + 1'b1;
        if (word_idx_q == len_q - 1'b1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          state_d = S_DONE;
          done_d  = (byte_data == csum_q);
          error_d = (byte_data != csum_q);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign core_hold = busy;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
